pht_port_arbiter: RTL and testbench
===================================

# pht_port_arbiter

Sequences and arbitrates the single port of the branch predictor's PHT LUTRAM (256 × 56-bit: {2-bit counter, 22-bit tag, 32-bit target}). It sits between the fetch-stage lookup and the branch-resolution update path. It clears the table after reset, buffers resolved-branch updates in a small queue, and grants each cycle's single RAM access to either a lookup or a queued write. It replaces "write always wins, read silently misses" with a bounded-starvation schedule.

## Interface
Parameters:
- PHT_NUMS, 256: table entries; IDX_W = log2(PHT_NUMS) = 8.
- DATA_WIDTH, 56: entry width.
- UQ_DEPTH, 4: update queue depth (power of 2, ≥2).
- STARVE_LIMIT, 8: maximum consecutive cycles a non-empty queue may be denied the port.
- CLEAR_WORD, {2'b11, 54'b0}: value written during the clear pass (counter = strongly-not-taken).

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- lk_req  in  1  fetch requests a lookup this cycle.
- lk_index  in  IDX_W  lookup index (fetch pc[9:2]).
- lk_grant  out  1  lookup owns the port this cycle; ram_dout is valid for lk_index.
- up_valid  in  1  resolved-branch update offered.
- up_index  in  IDX_W  update index.
- up_data  in  DATA_WIDTH  new entry.
- up_ready  out  1  queue can accept this cycle.
- ram_we  out  1  RAM write enable.
- ram_addr  out  IDX_W  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- init_busy  out  1  clear pass in progress.
- uq_count  out  log2(UQ_DEPTH)+1  queue occupancy.
- drop_cnt  out  8  saturating count of discarded updates.

## Operation
- States: INIT and RUN.
- INIT:
  - clr_idx walks 0..PHT_NUMS-1; each cycle ram_we=1, ram_addr=clr_idx, ram_din=CLEAR_WORD.
  - lk_grant=0 and up_ready=0.
  - At clr_idx=PHT_NUMS-1 the state goes to RUN next cycle.
- RUN, one RAM operation per cycle. Priority order:
  - (a) Write the queue head if the queue is non-empty and (!lk_req, or queue full, or starve_cnt ≥ STARVE_LIMIT). Drive ram_we=1, ram_addr=head.index, ram_din=head.data; lk_grant=0.
  - (b) Otherwise grant the lookup if lk_req. Drive lk_grant=1, ram_we=0, ram_addr=lk_index.
  - (c) Otherwise idle: ram_we=0, ram_addr=lk_index.
- starve_cnt:
  - Increments, saturating, in each cycle the queue is non-empty and no write is issued.
  - Clears on any write and whenever the queue is empty.
- up_ready = RUN and registered count < UQ_DEPTH.
  - Enqueue into a full queue is refused even if a dequeue happens the same cycle.
  - Enqueue and dequeue in the same cycle on a non-full queue leave the count unchanged.
- Updates are never stalled upstream. up_valid & !up_ready discards the update and increments drop_cnt, saturating at 255. This includes updates offered during INIT.
- No coalescing or forwarding. A lookup of an index with a pending queued update reads the stale entry; this is architecturally acceptable for prediction.
- Queue order is strict FIFO. Duplicate indices are written in arrival order.

## Timing
- Reset values:
  - State INIT, clr_idx=0, queue empty, starve_cnt=0, drop_cnt=0.
  - Outputs while resetn low: init_busy=1, ram_we=1, ram_addr=0, ram_din=CLEAR_WORD (idempotent), lk_grant=0, up_ready=0, uq_count=0, drop_cnt=0.
- The clear pass takes exactly PHT_NUMS cycles after resetn deasserts. The first lk_grant is possible in cycle PHT_NUMS.
- lk_grant is combinational from lk_req, registered queue state and starve_cnt. The RAM read is asynchronous, so data is valid in the grant cycle; fetch registers it.
- Update enqueued at edge t: earliest write in cycle t+1; visible to lookups from cycle t+2.
- Worst-case queue residency is STARVE_LIMIT+1 cycles per entry ahead of it.
- A mid-operation resetn assertion discards queue contents and restarts the clear pass.

## Structure
- Shared package bpu_pkg holds:
  - PHT_NUMS, IDX_W, DATA_WIDTH.
  - Counter encodings: S_Taken=01, W_Taken=00, WN_Taken=10, SN_Taken=11.
  - CLEAR_WORD.
  - Entry field offsets.
- Sub-module bpu_upd_fifo: synchronous FIFO with width IDX_W+DATA_WIDTH, depth UQ_DEPTH, count output, asynchronous active-low reset.
- The top level contains the INIT/RUN FSM, the starvation counter, the port mux and drop_cnt.

## Test plan
- Reset release with lk_req=1 → 256 writes of CLEAR_WORD to addresses 0..255, lk_grant=0 throughout, first lk_grant in cycle 256.
- In RUN, a single update (index 0x12) with lk_req=0 → enqueued; next cycle ram_we=1, ram_addr=0x12; lookup of 0x12 in the following cycle returns up_data.
- lk_req held at 1 with one queued update → lookups granted for 8 cycles, then one forced write (lk_grant=0), then lookups resume.
- 5 back-to-back updates with lk_req=1 → 4 accepted, 5th dropped (drop_cnt=1); queue full forces a write the next cycle.
- 2 updates to index 0x40 (data A then B) → writes occur in order; a lookup after the drain returns B.
- resetn pulsed low with 3 updates queued → uq_count=0, init_busy=1, clear restarts from address 0.

Source files
------------

// File: rtl/bpu_pkg.sv
// bpu_pkg: shared branch-predictor constants (PHT geometry, counter codes, entry layout).
`default_nettype none

package bpu_pkg;

  localparam int PHT_NUMS   = 256;
  localparam int IDX_W      = $clog2(PHT_NUMS);
  localparam int DATA_WIDTH = 56;

  localparam logic [1:0] S_Taken  = 2'b01;
  localparam logic [1:0] W_Taken  = 2'b00;
  localparam logic [1:0] WN_Taken = 2'b10;
  localparam logic [1:0] SN_Taken = 2'b11;

  // Entry layout: {counter, tag, target}
  localparam int TGT_LSB = 0;
  localparam int TGT_W   = 32;
  localparam int TAG_LSB = 32;
  localparam int TAG_W   = 22;
  localparam int CTR_LSB = 54;
  localparam int CTR_W   = 2;

  localparam logic [DATA_WIDTH-1:0] CLEAR_WORD = {SN_Taken, 54'b0};

endpackage

`default_nettype wire

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: small synchronous FIFO with occupancy count for resolved-branch updates.
`default_nettype none

module bpu_upd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pht_port_arbiter.sv
// pht_port_arbiter: clears the PHT after reset, then shares its single port between
// fetch lookups and queued branch updates with a bounded-starvation write schedule.
`default_nettype none

module pht_port_arbiter #(
  parameter int PHT_NUMS     = bpu_pkg::PHT_NUMS,
  parameter int DATA_WIDTH   = bpu_pkg::DATA_WIDTH,
  parameter int UQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_WORD = bpu_pkg::CLEAR_WORD,
  localparam int IDX_W = $clog2(PHT_NUMS),
  localparam int CNT_W = $clog2(UQ_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  lk_req,
  input  logic [IDX_W-1:0]      lk_index,
  output logic                  lk_grant,
  input  logic                  up_valid,
  input  logic [IDX_W-1:0]      up_index,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  ram_we,
  output logic [IDX_W-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  init_busy,
  output logic [CNT_W-1:0]      uq_count,
  output logic [7:0]            drop_cnt
);

  import bpu_pkg::*;

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int ENT_W = IDX_W + DATA_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] clr_idx;
  logic [STV_W-1:0] starve_cnt;

  logic             q_push;
  logic             q_pop;
  logic [ENT_W-1:0] q_head;
  logic             q_full;
  logic             q_empty;
  logic             run;
  logic             wr_issue;

  bpu_upd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (UQ_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (q_push),
    .din    ({up_index, up_data}),
    .pop    (q_pop),
    .dout   (q_head),
    .count  (uq_count),
    .full   (q_full),
    .empty  (q_empty)
  );

  assign run       = (state == ST_RUN);
  assign init_busy = !run;
  // Readiness uses the registered count only, so a full queue refuses even while draining.
  assign up_ready  = run && (uq_count < CNT_W'(UQ_DEPTH));
  assign q_push    = up_valid && up_ready;

  assign wr_issue = run && !q_empty &&
                    (!lk_req || q_full || (starve_cnt >= STV_W'(STARVE_LIMIT)));
  assign q_pop    = wr_issue;
  assign lk_grant = run && lk_req && !wr_issue;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = lk_index;
    ram_din  = q_head[DATA_WIDTH-1:0];
    if (!run) begin
      ram_we   = 1'b1;
      ram_addr = clr_idx;
      ram_din  = CLEAR_WORD;
    end else if (wr_issue) begin
      ram_we   = 1'b1;
      ram_addr = q_head[ENT_W-1 -: IDX_W];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_INIT;
      clr_idx <= '0;
    end else if (state == ST_INIT) begin
      clr_idx <= clr_idx + IDX_W'(1);
      if (clr_idx == IDX_W'(PHT_NUMS - 1)) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (q_empty || wr_issue) begin
      starve_cnt <= '0;
    end else if (starve_cnt < STV_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (up_valid && !up_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pht_port_arbiter.sv
// tb_pht_port_arbiter: randomized and directed stimulus checked against a queue-based model.
`default_nettype none

module tb_pht_port_arbiter;

  localparam int N     = 256;
  localparam int DW    = 56;
  localparam int UQ    = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          lk_req;
  logic [7:0]    lk_index;
  logic          lk_grant;
  logic          up_valid;
  logic [7:0]    up_index;
  logic [DW-1:0] up_data;
  logic          up_ready;
  logic          ram_we;
  logic [7:0]    ram_addr;
  logic [DW-1:0] ram_din;
  logic          init_busy;
  logic [2:0]    uq_count;
  logic [7:0]    drop_cnt;

  pht_port_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .lk_req    (lk_req),
    .lk_index  (lk_index),
    .lk_grant  (lk_grant),
    .up_valid  (up_valid),
    .up_index  (up_index),
    .up_data   (up_data),
    .up_ready  (up_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .init_busy (init_busy),
    .uq_count  (uq_count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles of clearing done, pending update list, RAM image.
  logic [DW-1:0] clear_w;
  logic [DW-1:0] mram [N];
  logic [DW-1:0] dram [N];
  logic [63:0]   mq [$];
  int            clr = 0;
  int            starve = 0;
  int            drops = 0;

  task automatic step(input bit rn, input bit lk, input logic [7:0] li,
                      input bit uv, input logic [7:0] ui, input logic [DW-1:0] ud);
    bit            e_we, e_gr, e_rdy, e_busy, wr;
    logic [7:0]    e_addr;
    logic [DW-1:0] e_din;
    logic [63:0]   head;
    int            qn;
    @(posedge clk);
    #1;
    resetn = rn; lk_req = lk; lk_index = li;
    up_valid = uv; up_index = ui; up_data = ud;
    if (!rn) begin
      clr = 0; mq.delete(); starve = 0; drops = 0;
    end
    #1;
    qn = mq.size();
    head = (qn > 0) ? mq[0] : 64'h0;
    wr = 1'b0;
    e_busy = (clr < N);
    if (e_busy) begin
      e_we = 1'b1; e_addr = 8'(clr); e_din = clear_w; e_gr = 1'b0; e_rdy = 1'b0;
    end else begin
      wr     = (qn > 0) && (!lk || qn == UQ || starve >= LIMIT);
      e_we   = wr;
      e_addr = wr ? head[63:56] : li;
      e_din  = head[DW-1:0];
      e_gr   = lk && !wr;
      e_rdy  = (qn < UQ);
    end
    check("init_busy", 64'(init_busy), 64'(e_busy));
    check("ram_we",    64'(ram_we),    64'(e_we));
    check("ram_addr",  64'(ram_addr),  64'(e_addr));
    if (e_we) check("ram_din", 64'(ram_din), 64'(e_din));
    check("lk_grant",  64'(lk_grant),  64'(e_gr));
    check("up_ready",  64'(up_ready),  64'(e_rdy));
    check("uq_count",  64'(uq_count),  64'(qn));
    check("drop_cnt",  64'(drop_cnt),  64'(drops));
    if (e_gr && lk_grant) check("lk_data", 64'(dram[li]), 64'(mram[li]));
    if (ram_we) dram[ram_addr] = ram_din;
    if (rn) begin
      if (e_busy) begin
        mram[clr] = clear_w;
        clr++;
        if (uv && drops < 255) drops++;
      end else begin
        if (wr) begin
          mram[head[63:56]] = head[DW-1:0];
          void'(mq.pop_front());
        end
        if (uv) begin
          if (e_rdy) mq.push_back({ui, ud});
          else if (drops < 255) drops++;
        end
        if (qn == 0 || wr) starve = 0;
        else if (starve < LIMIT) starve++;
      end
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [DW-1:0] da, db;
    int pl, pu;
    clear_w = {2'b11, 54'b0};
    for (int i = 0; i < N; i++) begin
      mram[i] = '0;
      dram[i] = '1;
    end
    resetn = 1'b0; lk_req = 1'b1; lk_index = '0;
    up_valid = 1'b0; up_index = '0; up_data = '0;

    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 0, 8'h0, '0);
    // Clear pass with lookups pending and updates offered (all dropped).
    for (int i = 0; i < N + 4; i++)
      step(1, 1, 8'($urandom), ($urandom_range(0, 1) == 1), 8'($urandom), rnd_data());

    da = rnd_data();
    step(1, 0, 8'h00, 1, 8'h12, da);
    step(1, 0, 8'h00, 0, 8'h00, '0);
    step(1, 1, 8'h12, 0, 8'h00, '0);

    step(1, 1, 8'h01, 1, 8'h33, rnd_data());
    for (int i = 0; i < 12; i++) step(1, 1, 8'($urandom), 0, 8'h0, '0);

    for (int i = 0; i < 5; i++) step(1, 1, 8'($urandom), 1, 8'($urandom), rnd_data());
    for (int i = 0; i < 6; i++) step(1, 1, 8'($urandom), 0, 8'h0, '0);

    da = rnd_data(); db = rnd_data();
    step(1, 0, 8'h00, 1, 8'h40, da);
    step(1, 0, 8'h00, 1, 8'h40, db);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 8'h0, '0);
    step(1, 1, 8'h40, 0, 8'h00, '0);

    for (int blk = 0; blk < 20; blk++) begin
      pl = $urandom_range(0, 100);
      pu = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++)
        step(1, ($urandom_range(0, 99) < pl), 8'h40 + 8'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < pu), 8'h40 + 8'($urandom_range(0, 7)), rnd_data());
    end

    // Heavy update pressure drives drop_cnt into saturation.
    for (int i = 0; i < 700; i++) step(1, 1, 8'($urandom), 1, 8'($urandom), rnd_data());

    for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom), 1, 8'($urandom), rnd_data());
    step(0, 1, 8'h05, 1, 8'h06, rnd_data());
    step(0, 1, 8'h05, 0, 8'h06, '0);
    for (int i = 0; i < N + 100; i++)
      step(1, ($urandom_range(0, 1) == 1), 8'($urandom),
           ($urandom_range(0, 3) == 0), 8'($urandom), rnd_data());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
